multicycle_control_unit: RTL and testbench
==========================================

# multicycle_control_unit

Multi-cycle sequencer for the RV32I single-issue datapath. It owns instruction fetch and data-memory handshakes and walks each instruction through FETCH/DECODE/EXECUTE/MEM/WB. Per state it drives the datapath controls (ALU_Controls, reg_wr_en, ALUSrcMuxSel, RAM2RegWSel, branch, JAL, JALR) plus a one-cycle PC update enable. It sits between the instruction/data memories and the datapath and replaces the single-cycle combinational decoder.

## Interface
- No parameters.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- iData  in  32  instruction word from instruction memory; valid when i_ready=1.
- i_req  out  1  instruction fetch request.
- i_ready  in  1  instruction memory accepts/returns iData this cycle.
- d_req  out  1  data memory access request.
- d_we  out  1  data memory write (store) qualifier for d_req.
- d_ready  in  1  data memory access complete this cycle.
- ALU_Controls  out  4  ALU operation.
- reg_wr_en  out  1  register file write enable.
- ALUSrcMuxSel  out  1  ALU B input select; 0 = rs2, 1 = immediate.
- RAM2RegWSel  out  3  writeback select; 0 = ALU, 1 = dRdata, 2 = imm, 3 = PC+imm, 4 = PC+4.
- branch, JAL, JALR  out  1 each  PC-redirect qualifiers to the datapath.
- pc_en  out  1  PC register load enable; exactly one cycle per retired instruction.
- ir_en  out  1  instruction register load enable (= i_req & i_ready).
- illegal_instr  out  1  sticky flag; unsupported opcode fetched.
- instret  out  32  retired-instruction counter.

## Operation
- Latched fields: opcode, funct3, funct7[5]. They are captured on ir_en and held until the next fetch.
- States: IDLE (after reset), FETCH, DECODE, EXECUTE, MEM, WB, TRAP.
- IDLE -> FETCH unconditionally.
- FETCH: i_req=1; stays until i_ready, then -> DECODE.
- DECODE -> TRAP if opcode is not one of 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111. Otherwise -> EXECUTE.
- EXECUTE transitions by instruction class:
  - R/I-ALU, LUI, AUIPC, JAL, JALR -> WB.
  - Load/store -> MEM.
  - B-type: branch=1, pc_en=1 -> FETCH.
- MEM: d_req=1; d_we=1 for stores. It holds until d_ready.
  - Store: pc_en=1 on d_ready -> FETCH.
  - Load: -> WB on d_ready.
- WB: reg_wr_en=1, pc_en=1 -> FETCH. JAL/JALR are asserted in WB together with RAM2RegWSel=4.
- TRAP: all enables 0, illegal_instr=1. The state persists until reset.
- ALU_Controls encoding:
  - R-type: {funct7[5], funct3}.
  - I-ALU: {funct3==101 ? funct7[5] : 0, funct3}.
  - Load/store/JALR: 0000 (ADD).
  - B-type: {1, funct3}; the ALU interprets it as a compare when branch=1.
- ALUSrcMuxSel = 1 for I-ALU, load, store, and JALR; otherwise 0.
- RAM2RegWSel: 0 for ALU ops, 1 for load, 2 for LUI, 3 for AUIPC, 4 for JAL/JALR.
- Control outputs are valid in every state. They are decoded from the latched fields, so they hold steady through EXECUTE/MEM/WB.
- instret increments on every pc_en. It wraps 0xFFFFFFFF -> 0.

## Timing
- Reset (rst=0) forces state IDLE and the following output values:
  - i_req, d_req, d_we, reg_wr_en, pc_en, ir_en, branch, JAL, JALR, illegal_instr = 0.
  - ALU_Controls = 0, RAM2RegWSel = 0, instret = 0.
- The first i_req occurs 2 cycles after rst deasserts (IDLE, then FETCH).
- Minimum cycles per instruction, with zero-wait memories (i_ready/d_ready=1):
  - Branch: 3.
  - ALU, LUI, AUIPC, JAL, JALR: 4.
  - Store: 4.
  - Load: 5.
- Each cycle that i_ready or d_ready is low adds one cycle in FETCH or MEM.
- i_req and d_req are never asserted in the same cycle.
- i_req and d_req remain high until their ready is sampled high. They drop in the cycle after.
- pc_en and reg_wr_en are single-cycle pulses. For a load, reg_wr_en coincides with pc_en in WB, never in MEM.
- Reset mid-operation is asynchronous: outputs go to their reset values immediately. An in-flight memory request is abandoned and the latched fields are cleared.
- A ready signal asserted while the FSM is not in the matching state is ignored.

## Test plan
- ADD x3,x1,x2 (0x002081B3), zero-wait: FETCH, DECODE, EXECUTE, WB. In WB: ALU_Controls=0000, ALUSrcMuxSel=0, RAM2RegWSel=0, reg_wr_en=1, pc_en=1. instret goes 0 -> 1.
- LW x5,8(x1) (0x0080A283), d_ready held low 3 cycles: d_req high 4 cycles, d_we=0. Then WB with RAM2RegWSel=1, reg_wr_en=1. Total 8 cycles.
- SW x5,12(x1) (0x0050A623): MEM with d_req=1, d_we=1, ALUSrcMuxSel=1, ALU_Controls=0000. pc_en pulses on d_ready. reg_wr_en is never 1.
- BEQ x0,x0,+8 (0x00000463): EXECUTE has branch=1, pc_en=1, ALU_Controls=1000. Next cycle is FETCH; 3 cycles total.
- JAL x1,16 (0x010000EF): WB has JAL=1, RAM2RegWSel=4, reg_wr_en=1, pc_en=1. Then 0xFFFFFFFF is fetched: TRAP, illegal_instr=1, no further i_req. After rst pulse low, illegal_instr=0 and instret=0.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I sequencer: walks each instruction through FETCH/DECODE/EXECUTE/MEM/WB,
// owns the instruction/data memory handshakes and drives the datapath controls per state.
module multicycle_control_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] iData,
    output logic        i_req,
    input  logic        i_ready,
    output logic        d_req,
    output logic        d_we,
    input  logic        d_ready,
    output logic [3:0]  ALU_Controls,
    output logic        reg_wr_en,
    output logic        ALUSrcMuxSel,
    output logic [2:0]  RAM2RegWSel,
    output logic        branch,
    output logic        JAL,
    output logic        JALR,
    output logic        pc_en,
    output logic        ir_en,
    output logic        illegal_instr,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_TRAP
    } state_t;

    typedef enum logic [3:0] {
        C_BAD, C_ALU_R, C_ALU_I, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_LUI, C_AUIPC
    } cls_t;

    state_t      state;
    cls_t        cls;
    cls_t        dec_cls;
    logic [3:0]  dec_alu;
    logic        dec_src;
    logic [2:0]  dec_wb;
    logic        pc_pulse;
    logic        unused_bits;

    assign unused_bits = ^{iData[31], iData[29:15], iData[11:7]};

    // Decode straight from the fetched word; the result is latched on ir_en
    always_comb begin
        dec_cls = C_BAD;
        dec_alu = 4'b0000;
        dec_src = 1'b0;
        dec_wb  = 3'd0;
        case (iData[6:0])
            7'b0110011: begin dec_cls = C_ALU_R; dec_alu = {iData[30], iData[14:12]}; end
            7'b0010011: begin
                dec_cls = C_ALU_I;
                dec_alu = {(iData[14:12] == 3'b101) ? iData[30] : 1'b0, iData[14:12]};
                dec_src = 1'b1;
            end
            7'b0000011: begin dec_cls = C_LOAD;   dec_src = 1'b1; dec_wb = 3'd1; end
            7'b0100011: begin dec_cls = C_STORE;  dec_src = 1'b1; end
            7'b1100011: begin dec_cls = C_BRANCH; dec_alu = {1'b1, iData[14:12]}; end
            7'b1101111: begin dec_cls = C_JAL;    dec_wb = 3'd4; end
            7'b1100111: begin dec_cls = C_JALR;   dec_src = 1'b1; dec_wb = 3'd4; end
            7'b0110111: begin dec_cls = C_LUI;    dec_wb = 3'd2; end
            7'b0010111: begin dec_cls = C_AUIPC;  dec_wb = 3'd3; end
            default:    dec_cls = C_BAD;
        endcase
    end

    assign ir_en = i_req & i_ready;
    // A store retires in MEM on the same cycle its data access completes
    assign pc_en = pc_pulse | (d_req & d_we & d_ready);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            cls           <= C_BAD;
            i_req         <= 1'b0;
            d_req         <= 1'b0;
            d_we          <= 1'b0;
            reg_wr_en     <= 1'b0;
            pc_pulse      <= 1'b0;
            branch        <= 1'b0;
            JAL           <= 1'b0;
            JALR          <= 1'b0;
            illegal_instr <= 1'b0;
            ALU_Controls  <= 4'b0000;
            ALUSrcMuxSel  <= 1'b0;
            RAM2RegWSel   <= 3'd0;
            instret       <= 32'd0;
        end else begin
            if (pc_en)
                instret <= instret + 32'd1;
            case (state)
                S_IDLE: begin
                    state <= S_FETCH;
                    i_req <= 1'b1;
                end
                S_FETCH: begin
                    if (i_ready) begin
                        state        <= S_DECODE;
                        i_req        <= 1'b0;
                        cls          <= dec_cls;
                        ALU_Controls <= dec_alu;
                        ALUSrcMuxSel <= dec_src;
                        RAM2RegWSel  <= dec_wb;
                    end
                end
                S_DECODE: begin
                    if (cls == C_BAD) begin
                        state         <= S_TRAP;
                        illegal_instr <= 1'b1;
                    end else begin
                        state <= S_EXECUTE;
                        if (cls == C_BRANCH) begin
                            branch   <= 1'b1;
                            pc_pulse <= 1'b1;
                        end
                    end
                end
                S_EXECUTE: begin
                    branch   <= 1'b0;
                    pc_pulse <= 1'b0;
                    if (cls == C_BRANCH) begin
                        state <= S_FETCH;
                        i_req <= 1'b1;
                    end else if (cls == C_LOAD || cls == C_STORE) begin
                        state <= S_MEM;
                        d_req <= 1'b1;
                        d_we  <= (cls == C_STORE);
                    end else begin
                        state     <= S_WB;
                        reg_wr_en <= 1'b1;
                        pc_pulse  <= 1'b1;
                        JAL       <= (cls == C_JAL);
                        JALR      <= (cls == C_JALR);
                    end
                end
                S_MEM: begin
                    if (d_ready) begin
                        d_req <= 1'b0;
                        d_we  <= 1'b0;
                        if (cls == C_STORE) begin
                            state <= S_FETCH;
                            i_req <= 1'b1;
                        end else begin
                            state     <= S_WB;
                            reg_wr_en <= 1'b1;
                            pc_pulse  <= 1'b1;
                        end
                    end
                end
                S_WB: begin
                    state     <= S_FETCH;
                    i_req     <= 1'b1;
                    reg_wr_en <= 1'b0;
                    pc_pulse  <= 1'b0;
                    JAL       <= 1'b0;
                    JALR      <= 1'b0;
                end
                S_TRAP:  state <= S_TRAP;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: runs a short RV32I program through a
// zero/variable-wait memory model and checks per-instruction controls and cycle counts.
module tb_multicycle_control_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] iData;
    logic        i_req, i_ready, d_req, d_we, d_ready;
    logic [3:0]  ALU_Controls;
    logic        reg_wr_en, ALUSrcMuxSel;
    logic [2:0]  RAM2RegWSel;
    logic        branch, JAL, JALR, pc_en, ir_en, illegal_instr;
    logic [31:0] instret;

    int errors = 0;
    int checks = 0;

    // Snapshot of outputs in the pc_en cycle plus per-instruction tallies
    int          cyc, n_dreq, n_both, n_rw_out, n_rw;
    logic        any_dwe;
    logic [3:0]  s_alu;
    logic        s_src, s_rw, s_br, s_jal, s_jalr, s_dreq, s_dwe;
    logic [2:0]  s_wb;
    int          n_ireq;

    multicycle_control_unit dut (
        .clk(clk), .rst(rst), .iData(iData),
        .i_req(i_req), .i_ready(i_ready),
        .d_req(d_req), .d_we(d_we), .d_ready(d_ready),
        .ALU_Controls(ALU_Controls), .reg_wr_en(reg_wr_en),
        .ALUSrcMuxSel(ALUSrcMuxSel), .RAM2RegWSel(RAM2RegWSel),
        .branch(branch), .JAL(JAL), .JALR(JALR),
        .pc_en(pc_en), .ir_en(ir_en),
        .illegal_instr(illegal_instr), .instret(instret)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Runs one instruction starting from a sampled FETCH cycle until its pc_en cycle
    task automatic run_instr(input logic [31:0] instr, input int iwait, input int dwait);
        int iseen, dseen;
        bit done;
        iseen = 0; dseen = 0; done = 0;
        cyc = 0; n_dreq = 0; n_both = 0; n_rw_out = 0; n_rw = 0; any_dwe = 0;
        iData = instr;
        for (int k = 0; k < 40 && !done; k++) begin
            cyc++;
            if (i_req) begin i_ready = (iseen >= iwait); iseen++; end
            else i_ready = 1'b1;
            if (d_req) begin d_ready = (dseen >= dwait); dseen++; end
            else d_ready = 1'b1;
            #1;
            if (i_req && d_req) n_both++;
            if (d_req) n_dreq++;
            if (d_we) any_dwe = 1'b1;
            if (reg_wr_en) n_rw++;
            if (reg_wr_en && !pc_en) n_rw_out++;
            if (pc_en) begin
                done   = 1;
                s_alu  = ALU_Controls; s_src = ALUSrcMuxSel; s_wb = RAM2RegWSel;
                s_rw   = reg_wr_en;    s_br  = branch;       s_jal = JAL;
                s_jalr = JALR;         s_dreq = d_req;       s_dwe = d_we;
            end else begin
                tick();
            end
        end
        if (!done) check("pc_en_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        rst = 1'b0; iData = 32'h0; i_ready = 1'b0; d_ready = 1'b0;
        tick(); tick();
        check("rst_ctrl", {i_req, d_req, d_we, reg_wr_en, pc_en, ir_en, branch, JAL, JALR, illegal_instr}, 10'b0);
        check("rst_alu", ALU_Controls, 4'b0000);
        check("rst_wbsel", RAM2RegWSel, 3'd0);
        check("rst_instret", instret, 32'd0);
        rst = 1'b1;
        i_ready = 1'b1; d_ready = 1'b1;
        #1 check("idle_no_ireq", i_req, 1'b0);
        tick();
        check("first_ireq", i_req, 1'b1);

        // ADD x3,x1,x2
        run_instr(32'h002081B3, 0, 0);
        check("add_cycles", cyc, 4);
        check("add_ctrl", {s_alu, s_src, s_wb, s_rw}, {4'b0000, 1'b0, 3'd0, 1'b1});
        check("add_instret_before", instret, 32'd0);
        tick();
        check("add_instret_after", instret, 32'd1);
        check("add_next_fetch", {i_req, reg_wr_en, pc_en}, 3'b100);

        // LW x5,8(x1) with three wait cycles
        run_instr(32'h0080A283, 0, 3);
        check("lw_cycles", cyc, 8);
        check("lw_dreq_cycles", n_dreq, 4);
        check("lw_dwe", any_dwe, 1'b0);
        check("lw_wb", {s_wb, s_rw, s_src, s_dreq}, {3'd1, 1'b1, 1'b1, 1'b0});
        check("lw_rw_outside_wb", n_rw_out, 0);
        tick();

        // SW x5,12(x1)
        run_instr(32'h0050A623, 0, 0);
        check("sw_cycles", cyc, 4);
        check("sw_mem", {s_dreq, s_dwe, s_src, s_alu}, {1'b1, 1'b1, 1'b1, 4'b0000});
        check("sw_no_regwr", n_rw, 0);
        tick();
        check("sw_dreq_drop", {d_req, i_req}, 2'b01);

        // BEQ x0,x0,+8
        run_instr(32'h00000463, 0, 0);
        check("beq_cycles", cyc, 3);
        check("beq_ctrl", {s_br, s_alu, s_rw}, {1'b1, 4'b1000, 1'b0});
        tick();
        check("beq_next_fetch", {i_req, branch, pc_en}, 3'b100);

        // ADDI x1,x0,1024: bit 30 set but funct3=000 keeps plain ADD
        run_instr(32'h40000093, 0, 0);
        check("addi_ctrl", {s_alu, s_src, s_wb}, {4'b0000, 1'b1, 3'd0});
        tick();

        // SRAI x1,x1,3
        run_instr(32'h4030D093, 0, 0);
        check("srai_ctrl", {s_alu, s_src}, {4'b1101, 1'b1});
        tick();

        // SUB x3,x1,x2 with two fetch wait cycles
        run_instr(32'h402081B3, 2, 0);
        check("sub_cycles", cyc, 6);
        check("sub_alu", s_alu, 4'b1000);
        tick();

        // JAL x1,16
        run_instr(32'h010000EF, 0, 0);
        check("jal_cycles", cyc, 4);
        check("jal_ctrl", {s_jal, s_jalr, s_wb, s_rw}, {1'b1, 1'b0, 3'd4, 1'b1});
        check("no_dual_req", n_both, 0);
        tick();
        check("instret_total", instret, 32'd8);

        // Illegal word traps and stops fetching
        iData = 32'hFFFFFFFF;
        i_ready = 1'b1;
        tick(); tick();
        check("trap_flag", illegal_instr, 1'b1);
        n_ireq = 0;
        for (int k = 0; k < 5; k++) begin
            if (i_req || d_req || pc_en || reg_wr_en) n_ireq++;
            tick();
        end
        check("trap_quiet", n_ireq, 0);
        check("trap_sticky", illegal_instr, 1'b1);

        // Asynchronous reset clears the flag and the counter without a clock edge
        #1 rst = 1'b0;
        #1;
        check("arst_illegal", illegal_instr, 1'b0);
        check("arst_instret", instret, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        check("restart_fetch", i_req, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
